// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares memory port B between the CPU and an I/O requester.
// Each access takes a GNT cycle (address/we out) and a DONE cycle (read data back).
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter bit RR_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_done,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, GNT_CPU, GNT_IO, DONE_CPU, DONE_IO} state_t;
  state_t r_state, w_next;
  logic r_last_io, r_we, w_pick_io;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_cpu_rdata, r_io_rdata;
  always_comb begin
    w_pick_io = io_req && (!cpu_req || (RR_MODE && !r_last_io));
    w_next = r_state == GNT_CPU ? DONE_CPU :
             r_state == GNT_IO  ? DONE_IO  :
             w_pick_io          ? GNT_IO   :
             cpu_req            ? GNT_CPU  : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_io   <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_io_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == GNT_CPU) begin
        r_we      <= cpu_we;
        r_addr    <= cpu_addr;
        r_wdata   <= cpu_wdata;
        r_last_io <= 1'b0;
      end
      if (w_next == GNT_IO) begin
        r_we      <= io_we;
        r_addr    <= io_addr;
        r_wdata   <= io_wdata;
        r_last_io <= 1'b1;
      end
      if (r_state == DONE_CPU && !r_we) r_cpu_rdata <= mem_rdata;
      if (r_state == DONE_IO && !r_we) r_io_rdata <= mem_rdata;
    end
  end
  // read data bypasses the holding register so it is valid alongside done
  assign cpu_rdata = (r_state == DONE_CPU && !r_we) ? mem_rdata : r_cpu_rdata;
  assign io_rdata  = (r_state == DONE_IO && !r_we) ? mem_rdata : r_io_rdata;
  assign cpu_gnt   = r_state == GNT_CPU;
  assign io_gnt    = r_state == GNT_IO;
  assign cpu_done  = r_state == DONE_CPU;
  assign io_done   = r_state == DONE_IO;
  assign mem_we    = r_we && (cpu_gnt || io_gnt);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the port-B arbiter, round-robin and
// fixed-priority instances side by side, with a synchronous RAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, io_req = 0, io_we = 0;
  logic [9:0] cpu_addr = 0, io_addr = 0;
  logic [15:0] cpu_wdata = 0, io_wdata = 0;
  logic cpu_gnt, cpu_done, io_gnt, io_done, mem_we;
  logic [15:0] cpu_rdata, io_rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr;
  logic fp_cpu_gnt, fp_cpu_done, fp_io_gnt, fp_io_done, fp_mem_we;
  logic [15:0] fp_cpu_rdata, fp_io_rdata, fp_mem_wdata;
  logic [15:0] fp_mem_rdata = 16'h0;
  logic [9:0] fp_mem_addr;
  logic pl_we = 0;
  logic [9:0] pl_a = 0;
  logic [15:0] pl_d = 0;
  logic [15:0] mem [1024];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_we) mem[pl_a] <= pl_d;
    mem_rdata <= mem[mem_addr];
  end

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RR_MODE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_done(io_done), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(fp_cpu_gnt), .cpu_done(fp_cpu_done), .cpu_rdata(fp_cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(fp_io_gnt), .io_done(fp_io_done), .io_rdata(fp_io_rdata),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we), .mem_rdata(fp_mem_rdata));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; cpu_req = 0; io_req = 0;
    @(negedge clk);
    reset = 0;
  endtask

  // one complete access by the chosen requester, checked at gnt and done
  task automatic access(input bit io, input bit we, input logic [9:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
    bit seen = 0;
    @(negedge clk);
    if (io) begin io_req = 1; io_we = we; io_addr = a; io_wdata = d; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = io ? io_gnt : cpu_gnt;
    end
    chk("gnt_seen", {31'd0, seen}, 32'd1);
    chk("gnt_addr", {22'd0, mem_addr}, {22'd0, a});
    chk("gnt_we", {31'd0, mem_we}, {31'd0, we});
    if (we) chk("gnt_wdata", {16'd0, mem_wdata}, {16'd0, d});
    if (io) io_req = 0; else cpu_req = 0;
    @(negedge clk);
    chk("done", {31'd0, io ? io_done : cpu_done}, 32'd1);
    chk("done_we", {31'd0, mem_we}, 32'd0);
    if (!we) chk("done_rdata", {16'd0, io ? io_rdata : cpu_rdata}, {16'd0, exp_rd});
  endtask

  initial begin
    logic [3:0] exp_tab [4];
    int rr_c, rr_i, fp_c, fp_i;
    bit seen;
    exp_tab[0] = 4'b1000; exp_tab[1] = 4'b0010; exp_tab[2] = 4'b0100; exp_tab[3] = 4'b0001;
    preload(10'h005, 16'hBEEF);
    preload(10'h010, 16'hA010);
    preload(10'h011, 16'hA011);
    do_reset();
    chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 0);
    chk("rst_io_done", {31'd0, io_done}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 0);

    access(0, 0, 10'h005, 16'h0, 16'hBEEF);
    @(negedge clk);
    chk("hold_cpu_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
    chk("hold_no_done", {31'd0, cpu_done}, 0);

    access(1, 1, 10'h3FF, 16'h1234, 16'h0);
    access(0, 0, 10'h3FF, 16'h0, 16'h1234);
    chk("io_rdata_kept", {16'd0, io_rdata}, 0);

    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    io_req = 1; io_we = 0; io_addr = 10'h3FF;
    rr_c = 0; rr_i = 0; fp_c = 0; fp_i = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 8) chk($sformatf("rr_seq%0d", c), {28'd0, cpu_gnt, io_gnt, cpu_done, io_done},
                     {28'd0, exp_tab[c % 4]});
      rr_c += int'(cpu_gnt); rr_i += int'(io_gnt);
      fp_c += int'(fp_cpu_gnt); fp_i += int'(fp_io_gnt);
    end
    chk("rr_cpu_cnt", rr_c, 5);
    chk("rr_io_cnt", rr_i, 5);
    chk("fp_cpu_cnt", fp_c, 10);
    chk("fp_io_cnt", fp_i, 0);
    cpu_req = 0;
    seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      seen = fp_io_gnt;
    end
    chk("fp_io_after_drop", {31'd0, seen}, 1);
    io_req = 0;
    repeat (3) @(negedge clk);

    access(1, 0, 10'h005, 16'h0, 16'hBEEF);
    @(negedge clk);
    io_req = 1; io_we = 0; io_addr = 10'h010;
    @(negedge clk);
    chk("mid_io_gnt", {31'd0, io_gnt}, 1);
    reset = 1; io_req = 0;
    @(negedge clk);
    chk("mid_io_done", {31'd0, io_done}, 0);
    chk("mid_io_gnt_off", {31'd0, io_gnt}, 0);
    chk("mid_mem_addr", {22'd0, mem_addr}, 0);
    chk("mid_cpu_rdata", {16'd0, cpu_rdata}, 0);
    chk("mid_io_rdata", {16'd0, io_rdata}, 0);
    reset = 0; cpu_req = 1; cpu_addr = 10'h005; io_req = 1;
    @(negedge clk);
    chk("post_rst_cpu_first", {30'd0, cpu_gnt, io_gnt}, 32'b10);
    cpu_req = 0; io_req = 0;
    repeat (4) @(negedge clk);

    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
    @(negedge clk);
    chk("b2b_gnt1", {21'd0, cpu_gnt, mem_addr}, {21'd1, 10'h010});
    cpu_addr = 10'h011;
    @(negedge clk);
    chk("b2b_done1", {15'd0, cpu_done, cpu_rdata}, {15'd1, 16'hA010});
    @(negedge clk);
    chk("b2b_gnt2", {21'd0, cpu_gnt, mem_addr}, {21'd1, 10'h011});
    cpu_req = 0;
    @(negedge clk);
    chk("b2b_done2", {15'd0, cpu_done, cpu_rdata}, {15'd1, 16'hA011});
    @(negedge clk);
    chk("b2b_idle", {15'd0, cpu_gnt | cpu_done, cpu_rdata}, {15'd0, 16'hA011});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-side port of the dual-port program/data memory between two requesters: the CPU control FSM (load/store) and an I/O requester (display or UART DMA).
- Sits between both requesters and memory port B; the PC-driven instruction fetch on port A is untouched.
- Serialises accesses with a grant/done handshake and a fixed two-cycle access latency, using fixed-priority or round-robin selection.

Parameters:
- ADDR_W, 10, memory word-address width (matches the 10-bit PC space).
- DATA_W, 16, memory data width.
- RR_MODE, 1. 1 = round-robin on a tie; 0 = fixed priority, CPU always wins.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_gnt is seen.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted, memory being accessed.
- cpu_done  out  1  one-cycle pulse: CPU access complete, cpu_rdata valid for reads.
- cpu_rdata  out  DATA_W  registered read data; holds until the next CPU read completes.
- io_req, io_we, io_addr, io_wdata, io_gnt, io_done, io_rdata: identical set for the I/O requester.
- mem_addr  out  ADDR_W  port-B address.
- mem_wdata  out  DATA_W  port-B write data.
- mem_we  out  1  port-B write enable.
- mem_rdata  in  DATA_W  port-B read data; synchronous RAM, valid one cycle after the address is presented.

Behaviour:
- State machine states: IDLE, GNT_CPU, GNT_IO, DONE_CPU, DONE_IO.
- Arbitration runs in IDLE, DONE_CPU and DONE_IO, using the req values sampled at the clock edge.
  - Neither req high: go to IDLE.
  - Only one req high: go to that requester's GNT state.
  - Both high with RR_MODE=1: grant the requester not recorded in last_srv.
  - Both high with RR_MODE=0: grant the CPU.
- On the edge entering GNT_x:
  - latch x's we, addr and wdata into mem_we, mem_addr and mem_wdata;
  - set last_srv to x.
- GNT_x lasts one cycle:
  - x_gnt=1;
  - mem_we equals the latched we, for that cycle only;
  - next state is DONE_x unconditionally;
  - req inputs are not sampled.
- DONE_x lasts one cycle:
  - x_done=1;
  - for a read, x_rdata is loaded from mem_rdata at the end of the cycle and is therefore visible from the cycle after done;
  - for a write, x_rdata is unchanged;
  - mem_we=0;
  - arbitration is evaluated as described above.
- Correction to the done/rdata timing: x_rdata must be valid in the same cycle x_done is high. To achieve this, x_rdata is driven combinationally from mem_rdata during DONE_x (read case) and from its holding register at all other times. The holding register captures mem_rdata at the end of DONE_x.
- Requester rule: after the cycle in which x_gnt is high, the requester may drop req or present a new access. A req seen high in DONE_x is a new request (back-to-back allowed).
- Latency and throughput:
  - req high at edge k, GNT at cycle k+1, DONE at cycle k+2;
  - peak throughput is one access per two cycles.
- Outputs outside GNT: mem_addr and mem_wdata hold their last latched values; mem_we=0.
- Reset (synchronous, any state, including mid-access):
  - state goes to IDLE; last_srv goes to IO, so the CPU wins the first tie;
  - all gnt, done and we outputs go to 0;
  - mem_addr, mem_wdata and both rdata registers go to 0.
  - A write already issued in GNT is not undone; the access completes no handshake.
- Starvation: with RR_MODE=0 and cpu_req held high continuously, the I/O requester is never granted. This is accepted behaviour.
- No combinational path from any req input to any gnt, done or mem_* output.

Test Plan:
- Single CPU read:
  - Stimulus: mem[0x005]=0xBEEF; cpu_req=1, cpu_we=0, cpu_addr=0x005 at edge 1.
  - Response: cycle 2 cpu_gnt=1, mem_addr=0x005, mem_we=0; cycle 3 cpu_done=1, cpu_rdata=0xBEEF, which then holds.
- I/O write then CPU read of the same address:
  - Stimulus: io write 0x1234 to 0x3FF; then cpu read of 0x3FF.
  - Response: io gnt cycle has mem_we=1, mem_wdata=0x1234; cpu_rdata=0x1234 at cpu_done; io_rdata unchanged.
- Round-robin tie (RR_MODE=1):
  - Stimulus: both req high from reset and both kept high.
  - Response: grant order CPU, IO, CPU, IO; gnts separated by 2 cycles; no idle cycles.
- Fixed priority (RR_MODE=0):
  - Stimulus: cpu_req and io_req held high for 20 cycles.
  - Response: 10 cpu_gnt pulses, 0 io_gnt. After cpu_req drops, io_gnt follows within 2 cycles.
- Reset mid-access:
  - Stimulus: assert reset in the GNT_IO cycle of an io read.
  - Response: next cycle IDLE; all outputs 0; no io_done. A following cpu_req is granted first (last_srv=IO).
- Back-to-back CPU:
  - Stimulus: cpu reads of 0x010 then 0x011, with the new address presented right after gnt.
  - Response: gnts at cycles 2 and 4; dones at cycles 3 and 5; correct data each time.
